// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_rx_fifo : PS/2 keyboard receiver with glitch filter, frame checking    |
// |               and a first-word-fall-through scancode FIFO.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module ps2_rx_fifo_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;

    // Both sync and filter idle high so reset looks like an idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            if (w_synced != r_level) begin
                if (r_cnt == FW'(FILTER_LEN - 1)) begin
                    r_level <= w_synced;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + FW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    output logic [7:0]                    scancode,
    output logic                          valid,
    input  logic                          pop,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          w_clk_level;
    logic          w_dat_level;
    logic          r_clk_level_d;
    logic          w_fe;

    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity_ok;
    logic [TW-1:0] r_timer;
    logic          r_push;
    logic [7:0]    r_push_data;
    logic          r_parity_error;
    logic          r_frame_error;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    ps2_rx_fifo_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_din   (PS2_CLK),
        .o_level (w_clk_level)
    );

    ps2_rx_fifo_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_dat_filter (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_din   (PS2_DAT),
        .o_level (w_dat_level)
    );

    assign w_fe = r_clk_level_d & ~w_clk_level;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clk_level_d  <= 1'b1;
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_parity_ok    <= 1'b0;
            r_timer        <= '0;
            r_push         <= 1'b0;
            r_push_data    <= '0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_clk_level_d  <= w_clk_level;
            r_push         <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;

            if (r_state == S_IDLE || w_fe) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            // Timer holds cycles since the last fe; abort once the gap hits the limit.
            if (r_state != S_IDLE && !w_fe && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                r_frame_error <= 1'b1;
                r_state       <= S_IDLE;
            end else if (w_fe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_dat_level) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_dat_level, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity_ok <= (^r_shift) ^ w_dat_level;
                        r_state     <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_dat_level) begin
                            r_frame_error <= 1'b1;
                        end else if (!r_parity_ok) begin
                            r_parity_error <= 1'b1;
                        end else begin
                            r_push      <= 1'b1;
                            r_push_data <= r_shift;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = pop & (r_count != '0);
    assign w_wr   = r_push & (~w_full | w_pop);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (r_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    // Storage is not reset, so mask the head while empty to present zero.
    assign valid        = (r_count != '0);
    assign scancode     = valid ? r_mem[r_rd_ptr] : 8'h00;
    assign count        = r_count;
    assign parity_error = r_parity_error;
    assign frame_error  = r_frame_error;
    assign overflow     = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_rx_fifo : self-checking bench for ps2_rx_fifo with a queue model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ps2_rx_fifo;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int FILT  = 8;
    localparam int TMO   = 400;
    localparam int HALF  = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic          PS2_CLK  = 1'b1;
    logic          PS2_DAT  = 1'b1;
    logic          pop      = 1'b0;
    logic [7:0]    scancode;
    logic          valid;
    logic [CW-1:0] count;
    logic          parity_error;
    logic          frame_error;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    int pe_seen = 0;
    int fe_seen = 0;
    int exp_pe = 0;
    int exp_fe = 0;
    logic [7:0] model_q[$];
    bit model_ovf = 1'b0;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .PS2_CLK      (PS2_CLK),
        .PS2_DAT      (PS2_DAT),
        .scancode     (scancode),
        .valid        (valid),
        .pop          (pop),
        .count        (count),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .overflow     (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (parity_error === 1'b1) pe_seen <= pe_seen + 1;
        if (frame_error === 1'b1)  fe_seen <= fe_seen + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par_flip, input bit stop_v);
        logic par;
        par = ~(^d) ^ par_flip;
        return {stop_v, par, d, 1'b0};
    endfunction

    // Frame rules: stop bit first, then odd parity, then FIFO space.
    task automatic model_frame(input logic [10:0] bits);
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(bits[i]);
        if (bits[10] == 1'b0)        exp_fe++;
        else if (ones % 2 == 0)      exp_pe++;
        else if (model_q.size() < DEPTH) model_q.push_back(bits[8:1]);
        else                         model_ovf = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = bits[i];
            if (glitch) begin
                repeat (6) @(negedge CLOCK_50);
                PS2_CLK = 1'b0;
                repeat (4) @(negedge CLOCK_50);
                PS2_CLK = 1'b1;
                repeat (HALF - 10) @(negedge CLOCK_50);
            end else begin
                repeat (HALF) @(negedge CLOCK_50);
            end
            PS2_CLK = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_v, input bit glitch);
        logic [10:0] bits;
        bits = make_frame(d, par_flip, stop_v);
        send_bits(bits, 11, glitch);
        PS2_DAT = 1'b1;
        repeat (2 * HALF) @(negedge CLOCK_50);
        model_frame(bits);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        @(negedge CLOCK_50);
        pop = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK_50);
        checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode: got %h expected 00", scancode); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", valid); end
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid); end
        checks++; if (scancode !== 8'h1C) begin errors++; $display("FAIL single_scancode: got %h expected 1c", scancode); end
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        checks++; if (pe_seen !== 0 || fe_seen !== 0) begin errors++; $display("FAIL single_no_errors: got pe=%0d fe=%0d expected 0/0", pe_seen, fe_seen); end
        do_pop();
        checks++; if (valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL single_pop: got valid=%b count=%0d expected 0/0", valid, count); end
    endtask

    task automatic test_errors();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++; if (pe_seen !== exp_pe || fe_seen !== exp_fe) begin errors++; $display("FAIL parity_pulse: got pe=%0d fe=%0d expected %0d/%0d", pe_seen, fe_seen, exp_pe, exp_fe); end
        checks++; if (count !== '0) begin errors++; $display("FAIL parity_count: got %0d expected 0", count); end
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        checks++; if (pe_seen !== exp_pe || fe_seen !== exp_fe) begin errors++; $display("FAIL stop_pulse: got pe=%0d fe=%0d expected %0d/%0d", pe_seen, fe_seen, exp_pe, exp_fe); end
        checks++; if (count !== '0) begin errors++; $display("FAIL stop_count: got %0d expected 0", count); end
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        checks++; if (pe_seen !== exp_pe || fe_seen !== exp_fe) begin errors++; $display("FAIL both_bad_pulse: got pe=%0d fe=%0d expected %0d/%0d", pe_seen, fe_seen, exp_pe, exp_fe); end
    endtask

    task automatic test_glitch();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        checks++; if (count !== CW'(1) || scancode !== 8'h5A) begin errors++; $display("FAIL glitch_rx: got count=%0d data=%h expected 1/5a", count, scancode); end
        checks++; if (pe_seen !== exp_pe || fe_seen !== exp_fe) begin errors++; $display("FAIL glitch_errors: got pe=%0d fe=%0d expected %0d/%0d", pe_seen, fe_seen, exp_pe, exp_fe); end
        do_pop();
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        int n;
        int got;
        int want;
        bits = make_frame(8'h29, 1'b0, 1'b1);
        send_bits(bits, 3, 1'b0);
        PS2_DAT = bits[3];
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        n = 0;
        got = -1;
        while (n < TMO + 200 && got < 0) begin
            @(negedge CLOCK_50);
            n++;
            if (n == HALF) begin
                PS2_CLK = 1'b1;
                PS2_DAT = 1'b1;
            end
            if (frame_error === 1'b1) got = n;
        end
        want = TMO + SYNC + FILT;
        checks++; if (got < want - 2 || got > want + 2) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d+-2", got, want); end
        exp_fe++;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (fe_seen !== exp_fe || count !== '0) begin errors++; $display("FAIL timeout_pulse: got fe=%0d count=%0d expected %0d/0", fe_seen, count, exp_fe); end
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        checks++; if (count !== CW'(1) || scancode !== 8'h29) begin errors++; $display("FAIL timeout_recover: got count=%0d data=%h expected 1/29", count, scancode); end
        do_pop();
    endtask

    task automatic test_random();
        logic [7:0] d;
        int kind;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 3);
            send_frame(d, kind == 2, kind != 3, 1'b0);
            checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL random_count[%0d]: got %0d expected %0d", i, count, model_q.size()); end
            checks++; if (pe_seen !== exp_pe || fe_seen !== exp_fe) begin errors++; $display("FAIL random_errors[%0d]: got pe=%0d fe=%0d expected %0d/%0d", i, pe_seen, fe_seen, exp_pe, exp_fe); end
            if (model_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                checks++; if (scancode !== model_q[0]) begin errors++; $display("FAIL random_head[%0d]: got %h expected %h", i, scancode, model_q[0]); end
                do_pop();
            end
        end
        while (model_q.size() > 0) begin
            checks++; if (valid !== 1'b1 || scancode !== model_q[0]) begin errors++; $display("FAIL random_drain: got valid=%b data=%h expected 1/%h", valid, scancode, model_q[0]); end
            do_pop();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL random_empty: got valid=%b expected 0", valid); end
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= DEPTH + 1; v++) send_frame(8'(v), 1'b0, 1'b1, 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", count, DEPTH); end
        checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", overflow, model_ovf); end
        for (int v = 1; v <= DEPTH; v++) begin
            checks++; if (scancode !== 8'(v) || scancode !== model_q[0]) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", v, scancode, 8'(v)); end
            do_pop();
        end
        checks++; if (valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL ovf_drained: got valid=%b count=%0d expected 0/0", valid, count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        send_bits(make_frame(8'hA5, 1'b0, 1'b1), 5, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (valid !== 1'b0 || count !== '0 || scancode !== 8'h00) begin errors++; $display("FAIL midreset_fifo: got valid=%b count=%0d data=%h expected 0/0/00", valid, count, scancode); end
        checks++; if (overflow !== 1'b0 || parity_error !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL midreset_flags: got ovf=%b pe=%b fe=%b expected 0/0/0", overflow, parity_error, frame_error); end
        model_q.delete();
        model_ovf = 1'b0;
        PS2_DAT = 1'b1;
        reset = 1'b0;
        repeat (TMO + 50) @(negedge CLOCK_50);
        checks++; if (count !== '0 || fe_seen !== exp_fe || pe_seen !== exp_pe) begin errors++; $display("FAIL midreset_idle: got count=%0d pe=%0d fe=%0d expected 0/%0d/%0d", count, pe_seen, fe_seen, exp_pe, exp_fe); end
        send_frame(8'h76, 1'b0, 1'b1, 1'b0);
        checks++; if (count !== CW'(1) || scancode !== 8'h76) begin errors++; $display("FAIL midreset_rx: got count=%0d data=%h expected 1/76", count, scancode); end
        do_pop();
        checks++; if (valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midreset_final: got valid=%b ovf=%b expected 0/0", valid, overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_glitch();
        test_timeout();
        test_random();
        test_overflow();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
